// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single-port memory with one outstanding access, bounded wait and fairness.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int DSTREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_ack,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy
);

    // Streak counter must hold DSTREAK and be at least 3 bits wide.
    localparam int SW_RAW = $clog2(DSTREAK + 1);
    localparam int SW     = (SW_RAW < 3) ? 3 : SW_RAW;
    // Wait counter must hold TIMEOUT.
    localparam int WW_RAW = $clog2(TIMEOUT + 1);
    localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;

    localparam logic [15:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t         state;
    logic [SW-1:0]  streak;
    logic [WW-1:0]  wcnt;

    logic           d_req;
    logic           d_bad;
    logic           streak_ok;
    logic           grant_d;
    logic           grant_if;
    logic           in_wait;
    logic           timeout_hit;

    assign d_req       = d_re | d_we;
    assign d_bad       = d_re & d_we;
    assign streak_ok   = (streak < SW'(DSTREAK));
    // Data wins unless it has used up its streak while a fetch waits.
    assign grant_d     = d_req & (streak_ok | ~if_req);
    assign grant_if    = if_req & ~grant_d;
    assign in_wait     = (state == IF_WAIT) || (state == D_WAIT);
    // True on the edge that would make this the TIMEOUT-th wait cycle.
    assign timeout_hit = (wcnt == WW'(TIMEOUT - 1));

    // Track consecutive data grants made while a fetch is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (!if_req) begin
                streak <= '0;
            end else if (grant_d) begin
                if (streak_ok) begin
                    streak <= streak + SW'(1);
                end
            end else begin
                streak <= '0;
            end
        end
    end

    // Count cycles spent waiting on the memory for the current access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (state == IDLE) begin
            wcnt <= '0;
        end else if (in_wait) begin
            wcnt <= wcnt + WW'(1);
        end
    end

    // Main controller: grant, strobe the memory, collect data, pulse ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            if_data   <= '0;
            if_ack    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        if (d_bad) begin
                            state   <= ACK;
                            d_ack   <= 1'b1;
                            err     <= 1'b1;
                            d_rdata <= ERR_DATA;
                        end else begin
                            state     <= D_WAIT;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_re    <= d_re & ~d_we;
                            mem_we    <= d_we & ~d_re;
                        end
                    end else if (grant_if) begin
                        state    <= IF_WAIT;
                        mem_addr <= if_addr;
                        mem_re   <= 1'b1;
                        mem_we   <= 1'b0;
                    end
                end
                IF_WAIT: begin
                    if (mem_rdy) begin
                        state   <= ACK;
                        if_ack  <= 1'b1;
                        if_data <= mem_rdata;
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= ACK;
                        if_ack  <= 1'b1;
                        err     <= 1'b1;
                        if_data <= ERR_DATA;
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                D_WAIT: begin
                    if (mem_rdy) begin
                        state <= ACK;
                        d_ack <= 1'b1;
                        // Stores complete without touching load data.
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= ACK;
                        d_ack   <= 1'b1;
                        err     <= 1'b1;
                        d_rdata <= ERR_DATA;
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized transaction-level
// model of arbitration, latency, timeout and error behaviour.
module tb_mem_arbiter;

    localparam int TO = 8;
    localparam int DS = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_data;
    logic        if_ack;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_if_data;
    logic [15:0] exp_d_rdata;

    mem_arbiter #(.TIMEOUT(TO), .DSTREAK(DS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_data(if_data), .if_ack(if_ack),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = 0;
        d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_rdy = 0;
        #2;
        checks++;
        if ({if_ack, d_ack, err, mem_re, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {if_ack, d_ack, err, mem_re, mem_we});
        end
        checks++;
        if ({if_data, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {if_data, d_rdata, mem_addr, mem_wdata});
        end
        tick();
        tick();
        rst = 1'b0;
        exp_if_data = 16'h0;
        exp_d_rdata = 16'h0;
    endtask

    task automatic test_single_load();
        d_re = 1'b1;
        d_addr = 16'h0040;
        tick();
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (mem_re !== 1'b1 || mem_we !== 1'b0 ||
                mem_addr !== 16'h0040 || d_ack !== 1'b0) begin
                errors++;
                $display("FAIL load_strobe c=%0d got re=%b we=%b a=%h ack=%b want 1 0 0040 0",
                         c, mem_re, mem_we, mem_addr, d_ack);
            end
            if (c == 3) begin
                mem_rdy = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            tick();
        end
        mem_rdy = 1'b0;
        checks++;
        if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 16'hBEEF ||
            mem_re !== 1'b0 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL load_ack got ack=%b err=%b d=%h re=%b ifack=%b want 1 0 beef 0 0",
                     d_ack, err, d_rdata, mem_re, if_ack);
        end
        exp_d_rdata = 16'hBEEF;
        d_re = 1'b0;
        tick();
        checks++;
        if (d_ack !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL load_ack_len got ack=%b err=%b want 0 0", d_ack, err);
        end
    endtask

    task automatic test_contention();
        string order;
        string want;
        order = "";
        want = "DDDDIDDDDI";
        d_re = 1'b1;
        d_addr = 16'h0100;
        if_req = 1'b1;
        if_addr = 16'h0200;
        for (int g = 0; g < 10; g++) begin
            tick();
            if (mem_re === 1'b1 && mem_addr === 16'h0100)
                order = {order, "D"};
            else if (mem_re === 1'b1 && mem_addr === 16'h0200)
                order = {order, "I"};
            else
                order = {order, "x"};
            mem_rdy = 1'b1;
            mem_rdata = 16'hA000 + 16'(g);
            tick();
            mem_rdy = 1'b0;
            checks++;
            if (want[g] == "D") begin
                if (d_ack !== 1'b1 || if_ack !== 1'b0 ||
                    d_rdata !== 16'hA000 + 16'(g)) begin
                    errors++;
                    $display("FAIL contention_ack g=%0d got d=%b i=%b data=%h want D",
                             g, d_ack, if_ack, d_rdata);
                end
                exp_d_rdata = 16'hA000 + 16'(g);
            end else begin
                if (if_ack !== 1'b1 || d_ack !== 1'b0 ||
                    if_data !== 16'hA000 + 16'(g)) begin
                    errors++;
                    $display("FAIL contention_ack g=%0d got d=%b i=%b data=%h want IF",
                             g, d_ack, if_ack, if_data);
                end
                exp_if_data = 16'hA000 + 16'(g);
            end
            tick();
        end
        checks++;
        if (order != want) begin
            errors++;
            $display("FAIL contention_order got %s want %s", order, want);
        end
        d_re = 1'b0;
        if_req = 1'b0;
    endtask

    task automatic test_illegal();
        d_re = 1'b1;
        d_we = 1'b1;
        d_addr = 16'h0007;
        tick();
        checks++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || d_ack !== 1'b1 ||
            err !== 1'b1 || d_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL illegal got re=%b we=%b ack=%b err=%b d=%h want 0 0 1 1 ffff",
                     mem_re, mem_we, d_ack, err, d_rdata);
        end
        exp_d_rdata = 16'hFFFF;
        d_re = 1'b0;
        d_we = 1'b0;
        tick();
        checks++;
        if (d_ack !== 1'b0 || err !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after got ack=%b err=%b re=%b we=%b want 0",
                     d_ack, err, mem_re, mem_we);
        end
    endtask

    task automatic test_timeout();
        // Start from known load data so the timeout value is visible.
        d_re = 1'b1;
        d_addr = 16'h0002;
        tick();
        mem_rdy = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        mem_rdy = 1'b0;
        d_re = 1'b0;
        tick();
        d_we = 1'b1;
        d_addr = 16'h1234;
        d_wdata = 16'h5A5A;
        tick();
        for (int w = 1; w <= TO; w++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h1234 ||
                mem_wdata !== 16'h5A5A || d_ack !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait w=%0d got we=%b re=%b a=%h wd=%h ack=%b",
                         w, mem_we, mem_re, mem_addr, mem_wdata, d_ack);
            end
            tick();
        end
        checks++;
        if (d_ack !== 1'b1 || err !== 1'b1 || mem_we !== 1'b0 ||
            d_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL timeout_ack got ack=%b err=%b we=%b d=%h want 1 1 0 ffff",
                     d_ack, err, mem_we, d_rdata);
        end
        exp_d_rdata = 16'hFFFF;
        d_we = 1'b0;
        tick();
        checks++;
        if (d_ack !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after got ack=%b err=%b want 0 0", d_ack, err);
        end
    endtask

    task automatic test_late_rdy();
        mem_rdy = 1'b1;
        mem_rdata = 16'h4321;
        tick();
        tick();
        checks++;
        if (if_ack !== 1'b0 || d_ack !== 1'b0 || mem_re !== 1'b0 ||
            mem_we !== 1'b0 || d_rdata !== exp_d_rdata || if_data !== exp_if_data) begin
            errors++;
            $display("FAIL late_rdy got i=%b d=%b re=%b we=%b dr=%h id=%h want 0 0 0 0 %h %h",
                     if_ack, d_ack, mem_re, mem_we, d_rdata, if_data,
                     exp_d_rdata, exp_if_data);
        end
        mem_rdy = 1'b0;
        if_req = 1'b1;
        if_addr = 16'h0ABC;
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 16'h0ABC) begin
            errors++;
            $display("FAIL late_rdy_next got re=%b a=%h want 1 0abc", mem_re, mem_addr);
        end
        mem_rdy = 1'b1;
        mem_rdata = 16'h1357;
        tick();
        mem_rdy = 1'b0;
        checks++;
        if (if_ack !== 1'b1 || err !== 1'b0 || if_data !== 16'h1357) begin
            errors++;
            $display("FAIL late_rdy_fetch got ack=%b err=%b d=%h want 1 0 1357",
                     if_ack, err, if_data);
        end
        exp_if_data = 16'h1357;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        if_req = 1'b1;
        if_addr = 16'h0F0F;
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 16'h0F0F) begin
            errors++;
            $display("FAIL rmf_strobe got re=%b a=%h want 1 0f0f", mem_re, mem_addr);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_re !== 1'b0 || if_ack !== 1'b0 || mem_addr !== 16'h0 ||
            if_data !== 16'h0 || d_rdata !== 16'h0) begin
            errors++;
            $display("FAIL rmf_async got re=%b ack=%b a=%h id=%h dr=%h want 0",
                     mem_re, if_ack, mem_addr, if_data, d_rdata);
        end
        exp_if_data = 16'h0;
        exp_d_rdata = 16'h0;
        if_addr = 16'h0EEE;
        tick();
        checks++;
        if (if_ack !== 1'b0 || err !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL rmf_held got ack=%b err=%b re=%b want 0", if_ack, err, mem_re);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 16'h0EEE || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL rmf_regrant got re=%b a=%h ack=%b want 1 0eee 0",
                     mem_re, mem_addr, if_ack);
        end
        mem_rdy = 1'b1;
        mem_rdata = 16'h2468;
        tick();
        mem_rdy = 1'b0;
        checks++;
        if (if_ack !== 1'b1 || err !== 1'b0 || if_data !== 16'h2468) begin
            errors++;
            $display("FAIL rmf_ack got ack=%b err=%b d=%h want 1 0 2468",
                     if_ack, err, if_data);
        end
        exp_if_data = 16'h2468;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int m_streak;
        int kind;
        int lat;
        bit dreq;
        bit gd;
        bit ok;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_re;
        logic        e_we;
        logic [15:0] rdata;
        m_streak = 0;
        for (int n = 0; n < 200; n++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1;
                if_addr = 16'($urandom);
            end
            if (!d_re && !d_we && $urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 9);
                d_addr = 16'($urandom);
                d_wdata = 16'($urandom);
                d_re = (kind == 0) || (kind >= 5);
                d_we = (kind <= 4);
            end
            dreq = d_re | d_we;
            if (!if_req && !dreq) begin
                m_streak = 0;
                mem_rdy = 1'($urandom);
                tick();
                mem_rdy = 1'b0;
                checks++;
                if (if_ack !== 1'b0 || d_ack !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle n=%0d got i=%b d=%b re=%b we=%b want 0",
                             n, if_ack, d_ack, mem_re, mem_we);
                end
                continue;
            end
            gd = dreq && (m_streak < DS || !if_req);
            if (!if_req) m_streak = 0;
            else if (gd) m_streak = (m_streak < DS) ? m_streak + 1 : DS;
            else m_streak = 0;
            if (gd && d_re && d_we) begin
                tick();
                checks++;
                if (d_ack !== 1'b1 || err !== 1'b1 || if_ack !== 1'b0 ||
                    d_rdata !== 16'hFFFF || mem_re !== 1'b0 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_illegal n=%0d got d=%b err=%b i=%b dr=%h re=%b we=%b",
                             n, d_ack, err, if_ack, d_rdata, mem_re, mem_we);
                end
                exp_d_rdata = 16'hFFFF;
                d_re = 1'b0;
                d_we = 1'b0;
                mem_rdy = 1'($urandom);
                tick();
                mem_rdy = 1'b0;
                continue;
            end
            e_addr = gd ? d_addr : if_addr;
            e_wdata = d_wdata;
            e_re = gd ? d_re : 1'b1;
            e_we = gd ? d_we : 1'b0;
            lat = $urandom_range(1, TO + 2);
            ok = (lat <= TO);
            rdata = 16'($urandom);
            tick();
            for (int w = 1; w <= TO; w++) begin
                checks++;
                if (mem_re !== e_re || mem_we !== e_we || mem_addr !== e_addr ||
                    (gd && mem_wdata !== e_wdata) || if_ack !== 1'b0 || d_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_wait n=%0d w=%0d got re=%b we=%b a=%h wd=%h want %b %b %h %h",
                             n, w, mem_re, mem_we, mem_addr, mem_wdata,
                             e_re, e_we, e_addr, e_wdata);
                end
                if (gd) begin
                    d_addr = 16'($urandom);
                    d_wdata = 16'($urandom);
                end else begin
                    if_addr = 16'($urandom);
                end
                if (w == lat) begin
                    mem_rdy = 1'b1;
                    mem_rdata = rdata;
                    tick();
                    break;
                end
                tick();
            end
            mem_rdy = 1'($urandom);
            mem_rdata = 16'($urandom);
            if (gd) begin
                if (!ok) exp_d_rdata = 16'hFFFF;
                else if (e_re) exp_d_rdata = rdata;
            end else begin
                exp_if_data = ok ? rdata : 16'hFFFF;
            end
            checks++;
            if (d_ack !== gd || if_ack !== !gd || err !== !ok ||
                d_rdata !== exp_d_rdata || if_data !== exp_if_data ||
                mem_re !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL rnd_ack n=%0d lat=%0d got d=%b i=%b err=%b dr=%h id=%h re=%b we=%b want %b %b %b %h %h",
                         n, lat, d_ack, if_ack, err, d_rdata, if_data, mem_re, mem_we,
                         gd, !gd, !ok, exp_d_rdata, exp_if_data);
            end
            if (gd) begin
                d_re = 1'b0;
                d_we = 1'b0;
            end else begin
                if_req = 1'b0;
            end
            tick();
            mem_rdy = 1'b0;
            checks++;
            if (d_ack !== 1'b0 || if_ack !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_ack_len n=%0d got d=%b i=%b err=%b want 0",
                         n, d_ack, if_ack, err);
            end
        end
        if_req = 1'b0;
        d_re = 1'b0;
        d_we = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_illegal();
        test_timeout();
        test_late_rdy();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
